// File: rtl/song_player.sv
// Auto-play sequencer: walks a song's note table in a synchronous ROM and drives
// note codes with programmable beat length and silent inter-note gaps.
module song_player #(
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] mode,
  input  logic       pause,
  input  logic [1:0] song_num,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [4:0] note,
  output logic       playing,
  output logic       done,
  output logic [5:0] idx
);

  localparam logic [2:0] AUTO_MODE = 3'b011;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int CW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  logic [2:0]    state;
  logic [4:0]    note_q;
  logic [3:0]    beat_cnt;
  logic [CW-1:0] cycle_cnt;
  logic [GW-1:0] gap_cnt;
  logic [1:0]    last_song;
  logic          sounding;

  assign rom_addr = {song_num, idx};
  assign sounding = (state == S_PLAY) || (state == S_GAP);

  // Pause silences the output in the same cycle; everything else comes from registers.
  always_comb begin
    note    = (pause && sounding) ? 5'd0 : note_q;
    playing = sounding && !pause;
    done    = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      note_q    <= 5'd0;
      idx       <= 6'd0;
      beat_cnt  <= 4'd0;
      cycle_cnt <= '0;
      gap_cnt   <= '0;
      last_song <= 2'd0;
    end else begin
      last_song <= song_num;
      if (mode != AUTO_MODE) begin
        state     <= S_IDLE;
        note_q    <= 5'd0;
        idx       <= 6'd0;
        beat_cnt  <= 4'd0;
        cycle_cnt <= '0;
        gap_cnt   <= '0;
      end else if (state != S_IDLE && song_num != last_song) begin
        state  <= S_FETCH;
        idx    <= 6'd0;
        note_q <= 5'd0;
      end else begin
        case (state)
          S_IDLE: begin
            state  <= S_FETCH;
            idx    <= 6'd0;
            note_q <= 5'd0;
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            // An all-zero entry marks the end of the song.
            if (rom_data == 8'h00) begin
              state <= S_DONE;
            end else begin
              note_q    <= rom_data[4:0];
              beat_cnt  <= {1'b0, rom_data[7:5]} + 4'd1;
              cycle_cnt <= '0;
              state     <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (!pause) begin
              if (cycle_cnt == BEAT_LAST) begin
                cycle_cnt <= '0;
                beat_cnt  <= beat_cnt - 4'd1;
                if (beat_cnt == 4'd1) begin
                  state   <= S_GAP;
                  gap_cnt <= '0;
                  note_q  <= 5'd0;
                end
              end else begin
                cycle_cnt <= cycle_cnt + CW'(1);
              end
            end
          end
          S_GAP: begin
            if (!pause) begin
              if (gap_cnt == GAP_LAST) begin
                gap_cnt <= '0;
                // The last table slot ends the song instead of wrapping the index.
                if (idx == 6'd63) begin
                  state <= S_DONE;
                end else begin
                  idx   <= idx + 6'd1;
                  state <= S_FETCH;
                end
              end else begin
                gap_cnt <= gap_cnt + GW'(1);
              end
            end
          end
          S_DONE: state <= S_DONE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
